// File: rtl/t02_wishbone_subordinate.sv
// ---------------------------------------------------------------------------
// t02_wishbone_subordinate
//
// Classic (non-pipelined) Wishbone B4 subordinate in front of a word-addressed
// register bank of DEPTH 32-bit words, mapped at byte address BASE_ADDR.
// It supports byte-lane writes and a fixed number of wait states.
//
// Parameters:
//   BASE_ADDR   - byte address of word 0
//   DEPTH       - number of 32-bit words (power of two, 2..256)
//   WAIT_CYCLES - extra cycles between request capture and response (0..15)
//
// Ports:
//   CLK    in   clock, all state changes on the rising edge
//   RST    in   synchronous reset, active high
//   CYC_I  in   bus cycle valid
//   STB_I  in   strobe; a transfer is requested when CYC_I & STB_I
//   WE_I   in   1 = write, 0 = read
//   ADR_I  in   [31:0] byte address, bits [1:0] ignored
//   DAT_I  in   [31:0] write data
//   SEL_I  in   [3:0]  byte-lane enables
//   DAT_O  out  [31:0] read data, valid only while ACK_O is high
//   ACK_O  out  one-cycle transfer-complete pulse
//   ERR_O  out  one-cycle error pulse for out-of-range accesses
//               (present only when T02_WB_ERR_EN is defined)
//
// Optional feature macro: T02_WB_ERR_EN
//   defined   - misses answer with ERR_O instead of ACK_O
//   undefined - misses answer with a normal ACK_O and read data 0
// ---------------------------------------------------------------------------
module t02_wishbone_subordinate #(
   parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [31:0] ADR_I,
   input  logic [31:0] DAT_I,
   input  logic [3:0]  SEL_I,
   output logic [31:0] DAT_O,
`ifdef T02_WB_ERR_EN
   output logic        ACK_O,
   output logic        ERR_O
`else
   output logic        ACK_O
`endif
);

   localparam int         IDX_W     = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [3:0]       wait_cnt;
   logic [3:0]       next_cnt;
   logic             enter_resp;

   // Live request decode
   logic             req;
   logic [31:0]      off;
   logic             req_hit;
   logic [IDX_W-1:0] req_idx;
   logic             unused_low_bits;

   // Request captured in IDLE, used while waiting
   logic             hold_we;
   logic             hold_hit;
   logic [IDX_W-1:0] hold_idx;
   logic [31:0]      hold_dat;
   logic [3:0]       hold_sel;

   // Request that completes on the edge entering RESP
   logic             eff_we;
   logic             eff_hit;
   logic [IDX_W-1:0] eff_idx;
   logic [31:0]      eff_dat;
   logic [3:0]       eff_sel;

   logic [31:0]      mem [DEPTH];

   assign req     = CYC_I & STB_I;
   // Unsigned wrap: addresses below BASE_ADDR become huge offsets and miss.
   assign off     = ADR_I - BASE_ADDR;
   assign req_hit = (off[31:2] < 30'(DEPTH));
   assign req_idx = off[IDX_W+1:2];
   assign unused_low_bits = ^off[1:0];

   // With no wait states the request completes on its own capture edge, so
   // the live bus values are used in IDLE; otherwise the held copy is used.
   always_comb begin
      if (state == ST_IDLE) begin
         eff_we  = WE_I;
         eff_hit = req_hit;
         eff_idx = req_idx;
         eff_dat = DAT_I;
         eff_sel = SEL_I;
      end else begin
         eff_we  = hold_we;
         eff_hit = hold_hit;
         eff_idx = hold_idx;
         eff_dat = hold_dat;
         eff_sel = hold_sel;
      end
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a value unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      next_cnt   = wait_cnt;
      enter_resp = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  next_state = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  next_state = ST_WAIT;
                  next_cnt   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            // Manager gave up: drop the transfer without a response.
            if (!req) begin
               next_state = ST_IDLE;
               next_cnt   = 4'd0;
            end else if (wait_cnt == 4'd1) begin
               next_state = ST_RESP;
               next_cnt   = 4'd0;
               enter_resp = 1'b1;
            end else begin
               next_cnt   = wait_cnt - 4'd1;
            end
         end
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // NOTE: registers are updated with non-blocking assignments so every
   // right-hand side reads the value from before this edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         ACK_O    <= 1'b0;
`ifdef T02_WB_ERR_EN
         ERR_O    <= 1'b0;
`endif
         DAT_O    <= 32'h0;
         hold_we  <= 1'b0;
         hold_hit <= 1'b0;
         hold_idx <= '0;
         hold_dat <= 32'h0;
         hold_sel <= 4'h0;
         // NOTE: the bank is cleared on reset because software relies on it
         // reading zero afterwards, so it is built from resettable flops
         // rather than an inferred RAM.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'h0;
         end
      end else begin
         state    <= next_state;
         wait_cnt <= next_cnt;

         if (state == ST_IDLE && req) begin
            hold_we  <= WE_I;
            hold_hit <= req_hit;
            hold_idx <= req_idx;
            hold_dat <= DAT_I;
            hold_sel <= SEL_I;
         end

`ifdef T02_WB_ERR_EN
         ACK_O <= enter_resp & eff_hit;
         ERR_O <= enter_resp & ~eff_hit;
`else
         ACK_O <= enter_resp;
`endif

         // Read data is only driven for the response cycle, zero otherwise.
         if (enter_resp && eff_hit && !eff_we) begin
            DAT_O <= mem[eff_idx];
         end else begin
            DAT_O <= 32'h0;
         end

         if (enter_resp && eff_hit && eff_we) begin
            for (int b = 0; b < 4; b++) begin
               if (eff_sel[b]) begin
                  mem[eff_idx][8*b +: 8] <= eff_dat[8*b +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_t02_wishbone_subordinate.sv
// ---------------------------------------------------------------------------
// tb_t02_wishbone_subordinate
//
// Three instances share one clock and differ only in WAIT_CYCLES (0, 3, 2);
// each has its own bus signals. A behavioural word-array model per instance
// predicts read data and response type from address arithmetic alone.
// ---------------------------------------------------------------------------
module tb_t02_wishbone_subordinate;

   localparam int          N    = 3;
   localparam logic [31:0] BASE = 32'h3300_0000;
   localparam int          DEP  = 64;
`ifdef T02_WB_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   function automatic int wait_of(input int i);
      case (i)
         0:       return 0;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   logic        clk;
   logic        rst   [N];
   logic        cyc   [N];
   logic        stb   [N];
   logic        we    [N];
   logic [31:0] adr   [N];
   logic [31:0] wdat  [N];
   logic [3:0]  sel   [N];
   logic [31:0] rdat  [N];
   logic        ack   [N];
   logic        err   [N];

   logic [31:0] model [N][DEP];

   int total;
   int bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      t02_wishbone_subordinate #(
         .BASE_ADDR  (BASE),
         .DEPTH      (DEP),
         .WAIT_CYCLES(wait_of(g))
      ) dut (
         .CLK   (clk),
         .RST   (rst[g]),
         .CYC_I (cyc[g]),
         .STB_I (stb[g]),
         .WE_I  (we[g]),
         .ADR_I (adr[g]),
         .DAT_I (wdat[g]),
         .SEL_I (sel[g]),
         .DAT_O (rdat[g]),
`ifdef T02_WB_ERR_EN
         .ACK_O (ack[g]),
         .ERR_O (err[g])
`else
         .ACK_O (ack[g])
`endif
      );
`ifndef T02_WB_ERR_EN
      assign err[g] = 1'b0;
`endif
   end

   // Reference model: byte offset from BASE decides hit, word = offset / 4.
   task automatic model_apply(input int i, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] e_rd, output bit e_ack,
                              output bit e_err);
      logic [31:0] o;
      bit          hit;
      int          idx;
      o     = a - BASE;
      hit   = (o < 32'(DEP * 4));
      idx   = int'(o / 32'd4);
      e_rd  = 32'h0;
      e_ack = hit || !ERR_EN;
      e_err = !hit && ERR_EN;
      if (hit) begin
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) model[i][idx][8*b +: 8] = d[8*b +: 8];
         end else begin
            e_rd = model[i][idx];
         end
      end
   endtask

   // Single transfer: drive on a falling edge, count falling edges until a
   // response is seen (bounded), then release the bus.
   task automatic xfer(input int i, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int lat,
                       output bit got_ack, output bit got_err);
      @(negedge clk);
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w;
      adr[i] = a; wdat[i] = d; sel[i] = s;
      lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = 32'h0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (ack[i] || err[i]) begin
            got_ack = ack[i];
            got_err = err[i];
            rd      = rdat[i];
            break;
         end
      end
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
   endtask

   task automatic test_reset;
      for (int i = 0; i < N; i++) rst[i] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         total++;
         if ({ack[i], err[i], rdat[i]} !== {1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs inst%0d: got ack=%b err=%b dat=%h want 0/0/0",
                     i, ack[i], err[i], rdat[i]);
         end
         rst[i] = 1'b0;
         for (int k = 0; k < DEP; k++) model[i][k] = 32'h0;
      end
   endtask

   task automatic test_write_read;
      logic [31:0] rd, e_rd;
      int          lat;
      bit          ga, ge, ea, ee;
      xfer(0, 1'b1, 32'h3300_0010, 32'hDEAD_BEEF, 4'hF, rd, lat, ga, ge);
      model_apply(0, 1'b1, 32'h3300_0010, 32'hDEAD_BEEF, 4'hF, e_rd, ea, ee);
      total++;
      if (lat !== 1 || ga !== 1'b1) begin
         bad++;
         $display("FAIL wr_ack: got lat=%0d ack=%b want lat=1 ack=1", lat, ga);
      end
      xfer(0, 1'b0, 32'h3300_0010, 32'h0, 4'hF, rd, lat, ga, ge);
      total++;
      if (lat !== 1 || ga !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL rd_data: got lat=%0d ack=%b dat=%h want 1/1/deadbeef", lat, ga, rd);
      end
      @(negedge clk);
      total++;
      if (rdat[0] !== 32'h0 || ack[0] !== 1'b0) begin
         bad++;
         $display("FAIL rd_after: got dat=%h ack=%b want 0/0", rdat[0], ack[0]);
      end
   endtask

   task automatic test_byte_lanes;
      logic [31:0] rd, e_rd;
      int          lat;
      bit          ga, ge, ea, ee;
      xfer(0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF, rd, lat, ga, ge);
      model_apply(0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF, e_rd, ea, ee);
      xfer(0, 1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, rd, lat, ga, ge);
      model_apply(0, 1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, e_rd, ea, ee);
      xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'b0001, rd, lat, ga, ge);
      total++;
      if (rd !== 32'h11BB_33DD || ga !== 1'b1) begin
         bad++;
         $display("FAIL byte_lanes: got dat=%h ack=%b want 11bb33dd/1", rd, ga);
      end
      // Empty lane mask still acknowledges but leaves the word alone.
      xfer(0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, lat, ga, ge);
      total++;
      if (ga !== 1'b1 || lat !== 1) begin
         bad++;
         $display("FAIL sel_zero_ack: got ack=%b lat=%0d want 1/1", ga, lat);
      end
      xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, lat, ga, ge);
      total++;
      if (rd !== 32'h11BB_33DD) begin
         bad++;
         $display("FAIL sel_zero_data: got %h want 11bb33dd", rd);
      end
   endtask

   task automatic test_wait_states;
      logic [31:0] rd;
      int          lat;
      bit          ga, ge;
      xfer(1, 1'b0, BASE, 32'h0, 4'hF, rd, lat, ga, ge);
      total++;
      if (lat !== 4 || ga !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL wait_lat: got lat=%0d ack=%b dat=%h want 4/1/0", lat, ga, rd);
      end
   endtask

   // STB held high across two reads: responses must be WAIT_CYCLES+2 apart.
   task automatic test_back_to_back(input int i);
      logic [31:0] e_rd, rd1, rd2;
      bit          ea, ee;
      int          n, first, second;
      model_apply(i, 1'b0, BASE + 32'h10, 32'h0, 4'hF, e_rd, ea, ee);
      @(negedge clk);
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b0; adr[i] = BASE + 32'h10; sel[i] = 4'hF;
      n = 0; first = -1; second = -1; rd1 = 32'h0; rd2 = 32'h0;
      while (n < 60 && second < 0) begin
         @(negedge clk);
         n++;
         if (ack[i] || err[i]) begin
            if (first < 0) begin first = n; rd1 = rdat[i]; end
            else begin second = n; rd2 = rdat[i]; end
         end
      end
      cyc[i] = 1'b0; stb[i] = 1'b0;
      total++;
      if (first !== wait_of(i) + 1 || second - first !== wait_of(i) + 2) begin
         bad++;
         $display("FAIL b2b_timing inst%0d: got first=%0d gap=%0d want %0d/%0d",
                  i, first, second - first, wait_of(i) + 1, wait_of(i) + 2);
      end
      total++;
      if (rd1 !== e_rd || rd2 !== e_rd) begin
         bad++;
         $display("FAIL b2b_data inst%0d: got %h %h want %h", i, rd1, rd2, e_rd);
      end
   endtask

   task automatic test_abort;
      logic [31:0] rd, e_rd;
      int          lat;
      bit          ga, ge, ea, ee, saw;
      saw = 1'b0;
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
      adr[1] = BASE + 32'h8; wdat[1] = 32'h5555_5555; sel[1] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      saw |= ack[1] | err[1];
      @(negedge clk);
      saw |= ack[1] | err[1];
      stb[1] = 1'b0;
      repeat (8) begin
         @(negedge clk);
         saw |= ack[1] | err[1];
      end
      cyc[1] = 1'b0; we[1] = 1'b0;
      total++;
      if (saw !== 1'b0) begin
         bad++;
         $display("FAIL abort_no_ack: got response=%b want 0", saw);
      end
      xfer(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat, ga, ge);
      model_apply(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, e_rd, ea, ee);
      total++;
      if (rd !== e_rd || ga !== 1'b1 || lat !== 4) begin
         bad++;
         $display("FAIL abort_no_write: got dat=%h ack=%b lat=%0d want %h/1/4", rd, ga, lat, e_rd);
      end
   endtask

   task automatic test_out_of_range;
      logic [31:0] rd, e_rd;
      int          lat;
      bit          ga, ge, ea, ee;
      logic [31:0] addrs [5];
      bit          wes   [5];
      addrs = '{BASE, 32'h3300_0100, 32'h32FF_FFFC, BASE, BASE + 32'hFC};
      wes   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 5; k++) begin
         xfer(0, wes[k], addrs[k], 32'h0BAD_F00D + 32'(k), 4'hF, rd, lat, ga, ge);
         model_apply(0, wes[k], addrs[k], 32'h0BAD_F00D + 32'(k), 4'hF, e_rd, ea, ee);
         total++;
         if ({ga, ge, rd} !== {ea, ee, e_rd} || lat !== 1) begin
            bad++;
            $display("FAIL range_%0d adr=%h: got ack=%b err=%b dat=%h lat=%0d want %b/%b/%h/1",
                     k, addrs[k], ga, ge, rd, lat, ea, ee, e_rd);
         end
      end
      // The miss write to word 64 must not alias onto word 0.
      total++;
      if (model[0][0] !== 32'h0BAD_F00D) begin
         bad++;
         $display("FAIL range_model: got %h want 0badf00d", model[0][0]);
      end
   endtask

   task automatic test_random(input int i, input int n);
      logic [31:0] a, d, rd, e_rd;
      logic [3:0]  s;
      bit          w, ga, ge, ea, ee;
      int          lat, r;
      for (int k = 0; k < n; k++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)      a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         else if (r < 7) a = BASE + 4 * $urandom_range(48, 63);
         else if (r < 9) a = BASE + 4 * $urandom_range(64, 90);
         else            a = BASE - 4 * $urandom_range(1, 8);
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         xfer(i, w, a, d, s, rd, lat, ga, ge);
         model_apply(i, w, a, d, s, e_rd, ea, ee);
         total++;
         if ({ga, ge, rd} !== {ea, ee, e_rd} || lat !== wait_of(i) + 1) begin
            bad++;
            $display("FAIL rnd inst%0d #%0d adr=%h we=%b: got ack=%b err=%b dat=%h lat=%0d want %b/%b/%h/%0d",
                     i, k, a, w, ga, ge, rd, lat, ea, ee, e_rd, wait_of(i) + 1);
         end
         if (k % 4 == 0) begin
            @(negedge clk);
            total++;
            if ({ack[i], err[i], rdat[i]} !== {1'b0, 1'b0, 32'h0}) begin
               bad++;
               $display("FAIL rnd_idle inst%0d: got ack=%b err=%b dat=%h want 0/0/0",
                        i, ack[i], err[i], rdat[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd;
      int          lat;
      bit          ga, ge, saw;
      for (int k = 0; k < 3; k++)
         xfer(2, 1'b1, BASE + 32'(4 * k), $urandom | 32'h1, 4'hF, rd, lat, ga, ge);
      @(negedge clk);
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
      adr[2] = BASE + 32'h20; wdat[2] = 32'hCAFE_F00D; sel[2] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
      total++;
      if (ack[2] !== 1'b0 || rdat[2] !== 32'h0) begin
         bad++;
         $display("FAIL rst_mid_out: got ack=%b dat=%h want 0/0", ack[2], rdat[2]);
      end
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw |= ack[2] | err[2];
      end
      total++;
      if (saw !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_no_ack: got response=%b want 0", saw);
      end
      for (int k = 0; k < DEP; k++) model[2][k] = 32'h0;
      for (int k = 0; k < DEP; k++) begin
         xfer(2, 1'b0, BASE + 32'(4 * k), 32'h0, 4'hF, rd, lat, ga, ge);
         total++;
         if (rd !== model[2][k] || ga !== 1'b1 || lat !== 3) begin
            bad++;
            $display("FAIL rst_mid_word%0d: got dat=%h ack=%b lat=%0d want %h/1/3",
                     k, rd, ga, lat, model[2][k]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
         adr[i] = 32'h0; wdat[i] = 32'h0; sel[i] = 4'h0;
         for (int k = 0; k < DEP; k++) model[i][k] = 32'h0;
      end
      test_reset;
      test_write_read;
      test_byte_lanes;
      test_wait_states;
      test_back_to_back(0);
      test_back_to_back(1);
      test_abort;
      test_out_of_range;
      test_random(0, 40);
      test_random(1, 30);
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/t02_wishbone_subordinate.md
Name: t02_wishbone_subordinate

Overview:
- Classic (non-pipelined) Wishbone B4 subordinate that answers the bus cycles issued by the team's wishbone manager.
- Backs a word-addressed register bank of DEPTH 32-bit words mapped at BASE_ADDR.
- Supports byte-lane writes and programmable wait states.
- Used as on-chip scratch memory for the CPU, and as a bench-side responder when verifying the manager.

Parameters:
- BASE_ADDR, 32'h3300_0000, byte address of word 0.
- DEPTH, 64, number of 32-bit words (power of two, 2..256).
- WAIT_CYCLES, 0, extra cycles inserted between request capture and ACK (0..15).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- CYC_I  input  1  bus cycle valid.
- STB_I  input  1  strobe; a transfer is requested when CYC_I & STB_I.
- WE_I  input  1  1 = write, 0 = read.
- ADR_I  input  32  byte address; bits [1:0] ignored.
- DAT_I  input  32  write data.
- SEL_I  input  4  byte-lane enables; SEL_I[n] covers DAT_I[8n+7:8n].
- DAT_O  output  32  read data.
- ACK_O  output  1  transfer-complete pulse.
- ERR_O  output  1  error pulse; present only with T02_WB_ERR_EN.

Behaviour:
- Reset (RST=1 at a clock edge):
  - FSM goes to IDLE; wait counter = 0.
  - ACK_O = 0, ERR_O = 0, DAT_O = 32'h0.
  - Every storage word = 32'h0.
  - Reset overrides any transfer in progress; no write occurs on that edge.
- Address decode:
  - off = ADR_I - BASE_ADDR, as a 32-bit unsigned wrap.
  - hit = (off >> 2) < DEPTH.
  - index = off[log2(DEPTH)+1:2].
  - Addresses below BASE_ADDR wrap to large offsets and therefore miss.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if CYC_I & STB_I, capture ADR_I, DAT_I, SEL_I, WE_I and the hit flag into holding registers.
    - WAIT_CYCLES = 0: go to RESP.
    - Otherwise: load counter with WAIT_CYCLES and go to WAIT.
  - WAIT: counter decrements each cycle. When it reaches 1 on the current edge, go to RESP.
    - If CYC_I or STB_I is low in any WAIT cycle, abort: go to IDLE, no write, no ACK.
  - RESP: ACK_O (or ERR_O) is high for exactly this one cycle, then unconditionally go to IDLE.
- Latency: ACK_O rises WAIT_CYCLES+1 cycles after the capture edge.
  - Back-to-back requests (STB held high) complete every WAIT_CYCLES+2 cycles, because one IDLE cycle always separates transfers.
- Write path, on the edge entering RESP, when the captured hit = 1 and WE = 1:
  - Only the bytes with SEL = 1 are updated.
  - SEL = 4'b0000 still gets an ACK and changes nothing.
- Read path, on the same edge, when the captured hit = 1 and WE = 0:
  - DAT_O is loaded with the stored word.
  - DAT_O is valid only while ACK_O = 1 and returns to 0 on the next edge.
  - Read data is a full word regardless of SEL.
- Miss (captured hit = 0): writes are dropped and DAT_O = 0. Response type depends on the optional feature.
- Inputs that change after capture are ignored. Only CYC_I/STB_I deassertion is monitored, and only in WAIT.
- ACK_O and ERR_O are never high together, and never high in IDLE or WAIT.

Optional Feature:
- Macro: T02_WB_ERR_EN.
- Defined:
  - ERR_O port exists.
  - A miss produces ERR_O = 1 for one cycle in RESP, with ACK_O = 0 and DAT_O = 0.
- Undefined:
  - ERR_O port is absent.
  - A miss produces a normal ACK_O pulse with DAT_O = 0; writes are silently dropped.

Test Plan (defaults unless noted):
- Write then read: write ADR 32'h3300_0010, DAT 32'hDEAD_BEEF, SEL 4'hF -> ACK one cycle after capture. Read of the same address -> ACK with DAT_O = 32'hDEAD_BEEF; DAT_O = 0 on the following cycle.
- Byte lanes: word 4 holds 32'h1122_3344; write DAT 32'hAABB_CCDD with SEL 4'b0101 -> readback 32'h11BB_33DD.
- Wait states: WAIT_CYCLES = 3, read of 32'h3300_0000 after reset -> ACK_O high exactly 4 cycles after the capture edge, DAT_O = 0. STB_I held high -> next ACK 5 cycles later.
- Abort: WAIT_CYCLES = 3, write 32'h3300_0008 = 32'h5555_5555, drop STB_I in the second WAIT cycle -> no ACK, and a later read of that address returns 0.
- Out of range: write 32'h3300_0100 (word 64) and read 32'h32FF_FFFC.
  - Without T02_WB_ERR_EN: ACK with DAT_O = 0, and word 0 is unchanged.
  - With T02_WB_ERR_EN: ERR_O pulses instead and ACK_O stays 0.
- Reset mid-transfer: WAIT_CYCLES = 2, assert RST during WAIT of a write -> ACK_O = 0, FSM in IDLE, all words read back 0.
